// File: rtl/mux_scan_ctrl.sv
// Round-robin scanner around a 4:1 mux; builds a 4-bit snapshot per scan.
// Optional SCAN_CHG_EN adds chg_mask (snapshot XOR previous snapshot).
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] snap_data,
  output logic       snap_valid,
  input  logic       snap_ready
`ifdef SCAN_CHG_EN
  ,
  output logic [3:0] chg_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             load;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q & ~snap_ready;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = 2'd0;
        if (start | cont) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        shadow_d[sel_q] = y_in;
        if (sel_q == 2'd3) begin
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 2'd1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        // a transfer and a reload may coincide; the reload wins
        if (!valid_q || snap_ready) begin
          load    = 1'b1;
          data_d  = shadow_q;
          valid_d = 1'b1;
          sel_d   = 2'd0;
          cnt_d   = '0;
          state_d = cont ? SETTLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 4'h0;
      data_q   <= 4'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SCAN_CHG_EN
  logic [3:0] chg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_q <= 4'h0;
    end else if (load) begin
      chg_q <= shadow_q ^ data_q;
    end
  end

  assign chg_mask = chg_q;
`endif

  assign sel        = sel_q;
  assign busy       = (state_q != IDLE);
  assign snap_data  = data_q;
  assign snap_valid = valid_q;

endmodule
